fifo_wr_arbiter: RTL

- Shares the single write port of the FIFO memory between NUM_REQ local requesters on the write clock domain.
- Round-robin arbitration with bounded bursts, so a producer's short packet lands contiguously in the FIFO.
- Drives winc/w_data toward the write-pointer/memory logic and consumes its full flag.
- Ready/valid style per requester: a word is transferred in the cycle where req[i] and grant[i] are both high.

---
 rtl/fifo_arb_pkg.sv | 46 ++++
 rtl/fifo_rr_pick.sv | 23 ++
 rtl/fifo_wr_arbiter.sv | 116 +++++++++++
 3 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared types and the round-robin search used by the FIFO write-port arbiter.
// rr_next works on a fixed 32-bit vector so one function serves every NUM_REQ up to 32.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    localparam int RR_MAX = 32;

    typedef struct packed {
        logic       found;
        logic [5:0] idx;
    } rr_res_t;

    // Rotate so start_idx sits at bit 0, take the lowest set bit, then map back modulo n.
    function automatic rr_res_t rr_next(
        input logic [RR_MAX-1:0] req_vec,
        input logic [5:0]        start_idx,
        input logic [6:0]        n
    );
        rr_res_t           res;
        logic [RR_MAX-1:0] rot;
        int                pos;
        rot = '0;
        res = '0;
        for (int k = 0; k < RR_MAX; k++) begin
            if (k < int'(n)) begin
                pos = int'(start_idx) + k;
                if (pos >= int'(n)) pos = pos - int'(n);
                rot[k] = req_vec[pos];
            end
        end
        for (int k = RR_MAX - 1; k >= 0; k--) begin
            if (rot[k]) begin
                pos = int'(start_idx) + k;
                if (pos >= int'(n)) pos = pos - int'(n);
                res.found = 1'b1;
                res.idx   = 6'(pos);
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/fifo_rr_pick.sv
// Combinational round-robin pick: first set request at or after start_idx, wrapping at NUM_REQ.
// Zero latency, no state; found is low when no request is set.
module fifo_rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_vec,
    input  logic [IDX_W-1:0]   start_idx,
    output logic               found,
    output logic [IDX_W-1:0]   pick_idx
);

    rr_res_t res;
    logic    unused_idx_hi;

    assign res           = rr_next(RR_MAX'(req_vec), 6'(start_idx), 7'(NUM_REQ));
    assign found         = res.found;
    assign pick_idx      = res.idx[IDX_W-1:0];
    assign unused_idx_hi = ^res.idx[5:IDX_W];

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin sharing of the FIFO write port among NUM_REQ requesters with bursts of up to MAX_BURST words.
// Grant/winc are combinational from the registered owner; full stalls the owner without losing its burst.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int width     = 8,
    parameter int MAX_BURST = 4,
    parameter int idx_w     = $clog2(NUM_REQ),
    parameter int cnt_w     = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1
) (
    input  logic                     w_clk,
    input  logic                     w_rst,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*width-1:0] req_data,
    input  logic                     full,
    output logic [NUM_REQ-1:0]       grant,
    output logic                     winc,
    output logic [width-1:0]         w_data,
    output logic [idx_w-1:0]         owner,
    output logic                     busy
);

    localparam logic [idx_w-1:0] LAST_IDX = idx_w'(NUM_REQ - 1);
    localparam logic [cnt_w-1:0] LAST_CNT = cnt_w'(MAX_BURST - 1);

    arb_state_e       state_q, state_d;
    logic [idx_w-1:0] owner_q, owner_d;
    logic [cnt_w-1:0] cnt_q, cnt_d;

    logic             req_own;
    logic             accept;
    logic             burst_end;
    logic [idx_w-1:0] start_idx;
    logic [idx_w-1:0] pick_idx;
    logic             pick_found;

    always_comb begin
        req_own = 1'b0;
        w_data  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (owner_q == idx_w'(i)) begin
                req_own = req[i];
                w_data  = req_data[i*width +: width];
            end
        end
    end

    // Explicit wrap so a non-power-of-two NUM_REQ never searches from a phantom index.
    assign start_idx = (owner_q == LAST_IDX) ? '0 : owner_q + 1'b1;

    fifo_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (idx_w)
    ) u_pick (
        .req_vec   (req),
        .start_idx (start_idx),
        .found     (pick_found),
        .pick_idx  (pick_idx)
    );

    assign accept    = ~w_rst & (state_q == GRANT) & req_own & ~full;
    assign burst_end = (state_q == GRANT) & ((accept & (cnt_q == LAST_CNT)) | ~req_own);

    always_comb begin
        grant = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            grant[i] = accept & (owner_q == idx_w'(i));
        end
    end

    assign winc  = accept;
    assign owner = owner_q;
    assign busy  = (state_q == GRANT);

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    owner_d = pick_idx;
                    cnt_d   = '0;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (burst_end) begin
                    if (pick_found) begin
                        owner_d = pick_idx;
                        cnt_d   = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (accept) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            state_q <= IDLE;
            owner_q <= LAST_IDX;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule
